// File: rtl/index_cursor_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | index_cursor_if : pixel scan, button and cursor-report signals      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface index_cursor_if #(
    parameter int SLOT_NUM = 8
);
    localparam int IW = $clog2(SLOT_NUM);
    localparam int CW = $clog2(SLOT_NUM + 1);

    logic [9:0]    x_cnt;
    logic [9:0]    y_cnt;
    logic          frame_start;
    logic          move_left;
    logic          move_right;
    logic          select;
    logic [CW-1:0] slot_count;
    logic [IW-1:0] index;
    logic          sel_valid;
    logic [IW-1:0] sel_index;
    logic          hit;
    logic [7:0]    r_data;
    logic [7:0]    g_data;
    logic [7:0]    b_data;

    modport master (
        output x_cnt, y_cnt, frame_start, move_left, move_right, select, slot_count,
        input  index, sel_valid, sel_index, hit, r_data, g_data, b_data
    );

    modport slave (
        input  x_cnt, y_cnt, frame_start, move_left, move_right, select, slot_count,
        output index, sel_valid, sel_index, hit, r_data, g_data, b_data
    );
endinterface
`default_nettype wire

// File: rtl/index_cursor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | index_cursor : hand-cursor slot tracker with blinking border frame  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module index_cursor #(
    parameter int          SLOT_NUM     = 8,
    parameter int          SLOT_X0      = 40,
    parameter int          SLOT_Y0      = 360,
    parameter int          SLOT_W       = 60,
    parameter int          SLOT_H       = 90,
    parameter int          SLOT_PITCH   = 70,
    parameter int          BORDER       = 3,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] HL_COLOR     = 24'hFFFF00
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    index_cursor_if.slave bus
);
    localparam int IW = $clog2(SLOT_NUM);
    localparam int CW = $clog2(SLOT_NUM + 1);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    if (SLOT_X0 + (SLOT_NUM - 1) * SLOT_PITCH + SLOT_W > 1023) begin : g_geom_check
        $error("index_cursor: rightmost slot exceeds x=1023");
    end
    if (BORDER < 1 || BORDER > SLOT_W / 2) begin : g_border_check
        $error("index_cursor: BORDER out of range");
    end

    logic [IW-1:0] r_index;
    logic [BW-1:0] r_blink_cnt;
    logic          r_visible;
    logic          r_sel_valid;
    logic [IW-1:0] r_sel_index;
    logic          r_hit;
    logic [23:0]   r_rgb;

    logic [CW-1:0] w_eff;
    logic [CW-1:0] w_last;
    logic [CW-1:0] w_moved;
    logic [IW-1:0] w_next_index;
    logic          w_active;
    logic          w_move;
    logic          w_select;

    logic [11:0]   w_ox;
    logic [11:0]   w_oy;
    logic [11:0]   w_x;
    logic [11:0]   w_y;
    logic          w_outer;
    logic          w_inner;
    logic          w_draw;

    assign w_eff    = (bus.slot_count > CW'(SLOT_NUM)) ? CW'(SLOT_NUM) : bus.slot_count;
    assign w_active = (w_eff != '0);
    assign w_last   = w_eff - CW'(1);
    assign w_move   = w_active && (bus.move_left ^ bus.move_right);
    assign w_select = w_active && bus.select;

    // Movement is evaluated in CW bits so a stale index above a shrunken hand still clamps.
    always_comb begin
        w_moved      = CW'(r_index);
        w_next_index = '0;
        if (w_move) begin
            if (bus.move_right) begin
                w_moved = (CW'(r_index) == w_last) ? '0 : CW'(r_index) + CW'(1);
            end else begin
                w_moved = (r_index == '0) ? w_last : CW'(r_index) - CW'(1);
            end
        end
        if (w_moved >= w_eff) begin
            w_moved = w_last;
        end
        if (w_active) begin
            w_next_index = IW'(w_moved);
        end
    end

    assign w_ox    = 12'(SLOT_X0) + 12'(r_index) * 12'(SLOT_PITCH);
    assign w_oy    = 12'(SLOT_Y0);
    assign w_x     = {2'b00, bus.x_cnt};
    assign w_y     = {2'b00, bus.y_cnt};
    assign w_outer = (w_x >= w_ox) && (w_x <= w_ox + 12'(SLOT_W)) &&
                     (w_y >= w_oy) && (w_y <= w_oy + 12'(SLOT_H));
    assign w_inner = (w_x >= w_ox + 12'(BORDER)) && (w_x <= w_ox + 12'(SLOT_W) - 12'(BORDER)) &&
                     (w_y >= w_oy + 12'(BORDER)) && (w_y <= w_oy + 12'(SLOT_H) - 12'(BORDER));
    assign w_draw  = w_outer && !w_inner && r_visible && w_active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_index     <= '0;
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
            r_sel_valid <= 1'b0;
            r_sel_index <= '0;
            r_hit       <= 1'b0;
            r_rgb       <= '0;
        end else begin
            r_index     <= w_next_index;
            r_sel_valid <= w_select;
            if (w_select) begin
                r_sel_index <= r_index;
            end
            // A move restarts the blink so the cursor is shown right away.
            if (w_move) begin
                r_blink_cnt <= '0;
                r_visible   <= 1'b1;
            end else if (bus.frame_start) begin
                if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_visible   <= ~r_visible;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
            r_hit <= w_draw;
            r_rgb <= w_draw ? HL_COLOR : 24'h000000;
        end
    end

    assign bus.index     = r_index;
    assign bus.sel_valid = r_sel_valid;
    assign bus.sel_index = r_sel_index;
    assign bus.hit       = r_hit;
    assign bus.r_data    = r_rgb[23:16];
    assign bus.g_data    = r_rgb[15:8];
    assign bus.b_data    = r_rgb[7:0];
endmodule
`default_nettype wire

// File: tb/tb_index_cursor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_index_cursor : directed self-checking bench for index_cursor     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_index_cursor;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    index_cursor_if #(.SLOT_NUM(8)) bus ();

    index_cursor #(.BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_move(input logic left, input logic right);
        bus.move_left  = left;
        bus.move_right = right;
        step();
        bus.move_left  = 1'b0;
        bus.move_right = 1'b0;
    endtask

    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.x_cnt       = '0;
        bus.y_cnt       = '0;
        bus.frame_start = 1'b0;
        bus.move_left   = 1'b0;
        bus.move_right  = 1'b0;
        bus.select      = 1'b0;
        bus.slot_count  = 4'd5;
        step();
        step();
        check("rst_index", 32'(bus.index), 32'd0);
        check("rst_sel_valid", 32'(bus.sel_valid), 32'd0);
        check("rst_sel_index", 32'(bus.sel_index), 32'd0);
        check("rst_hit", 32'(bus.hit), 32'd0);
        check("rst_rgb", {8'h00, bus.r_data, bus.g_data, bus.b_data}, 32'h0);

        rst_n = 1'b1;
        bus.x_cnt = 10'd40; bus.y_cnt = 10'd360;
        step();
        check("corner_hit", 32'(bus.hit), 32'd1);
        check("corner_rgb", {8'h00, bus.r_data, bus.g_data, bus.b_data}, 32'h00FFFF00);
        bus.x_cnt = 10'd45; bus.y_cnt = 10'd370;
        step();
        check("interior_hit", 32'(bus.hit), 32'd0);
        check("interior_rgb", {8'h00, bus.r_data, bus.g_data, bus.b_data}, 32'h0);
        bus.x_cnt = 10'd100; bus.y_cnt = 10'd450;
        step();
        check("far_corner_hit", 32'(bus.hit), 32'd1);

        pulse_move(1'b1, 1'b0);
        check("left_wrap", 32'(bus.index), 32'd4);
        pulse_move(1'b0, 1'b1);
        check("right_wrap", 32'(bus.index), 32'd0);
        pulse_move(1'b1, 1'b0);
        check("left_wrap2", 32'(bus.index), 32'd4);
        pulse_move(1'b1, 1'b1);
        check("both_no_move", 32'(bus.index), 32'd4);
        pulse_move(1'b0, 1'b1);
        check("right_to_0", 32'(bus.index), 32'd0);

        bus.x_cnt = 10'd110; bus.y_cnt = 10'd360;
        pulse_move(1'b0, 1'b1);
        check("move_idx1", 32'(bus.index), 32'd1);
        check("lat1_hit", 32'(bus.hit), 32'd0);
        step();
        check("lat2_hit", 32'(bus.hit), 32'd1);
        bus.x_cnt = 10'd40;
        step();
        check("old_slot_hit", 32'(bus.hit), 32'd0);

        bus.x_cnt = 10'd110;
        step();
        pulse_frame();
        check("blink_f1_hit", 32'(bus.hit), 32'd1);
        pulse_frame();
        step();
        check("blink_off_hit", 32'(bus.hit), 32'd0);
        step();
        check("blink_off_hit2", 32'(bus.hit), 32'd0);
        bus.x_cnt = 10'd40;
        pulse_move(1'b1, 1'b0);
        check("blink_move_idx", 32'(bus.index), 32'd0);
        check("blink_move_lat1", 32'(bus.hit), 32'd0);
        step();
        check("blink_restore_hit", 32'(bus.hit), 32'd1);
        pulse_frame();
        step();
        check("blink_cnt_reset_hit", 32'(bus.hit), 32'd1);

        bus.slot_count = 4'd8;
        pulse_move(1'b1, 1'b0);
        pulse_move(1'b1, 1'b0);
        check("idx6", 32'(bus.index), 32'd6);
        bus.slot_count = 4'd3;
        step();
        check("clamp_idx", 32'(bus.index), 32'd2);
        bus.slot_count = 4'd0;
        step();
        check("empty_idx", 32'(bus.index), 32'd0);
        bus.x_cnt = 10'd40; bus.y_cnt = 10'd360;
        step();
        check("empty_hit", 32'(bus.hit), 32'd0);
        bus.select = 1'b1;
        step();
        bus.select = 1'b0;
        check("empty_select", 32'(bus.sel_valid), 32'd0);
        pulse_move(1'b1, 1'b0);
        check("empty_move", 32'(bus.index), 32'd0);

        bus.slot_count = 4'd12;
        pulse_move(1'b1, 1'b0);
        check("oversize_wrap", 32'(bus.index), 32'd7);
        bus.slot_count = 4'd5;
        bus.move_right = 1'b1;
        step();
        bus.move_right = 1'b0;
        check("shrink_move_clamp", 32'(bus.index), 32'd4);
        pulse_move(1'b1, 1'b0);
        pulse_move(1'b1, 1'b0);
        check("idx2", 32'(bus.index), 32'd2);

        bus.select = 1'b1;
        pulse_move(1'b0, 1'b1);
        bus.select = 1'b0;
        check("sel_valid", 32'(bus.sel_valid), 32'd1);
        check("sel_index_old", 32'(bus.sel_index), 32'd2);
        check("sel_move_idx", 32'(bus.index), 32'd3);
        step();
        check("sel_one_cycle", 32'(bus.sel_valid), 32'd0);
        check("sel_index_hold", 32'(bus.sel_index), 32'd2);
        bus.select = 1'b1;
        step();
        check("b2b_sel1", 32'(bus.sel_valid), 32'd1);
        check("b2b_idx1", 32'(bus.sel_index), 32'd3);
        bus.move_left = 1'b1;
        step();
        bus.move_left = 1'b0;
        check("b2b_sel2", 32'(bus.sel_valid), 32'd1);
        check("b2b_idx2", 32'(bus.sel_index), 32'd3);

        bus.move_right = 1'b1;
        rst_n = 1'b0;
        bus.x_cnt = 10'd110;
        step();
        bus.select = 1'b0;
        bus.move_right = 1'b0;
        check("midrst_sel_valid", 32'(bus.sel_valid), 32'd0);
        check("midrst_index", 32'(bus.index), 32'd0);
        check("midrst_sel_index", 32'(bus.sel_index), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_black", {8'h00, bus.r_data, bus.g_data, bus.b_data}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
